// File: rtl/pc_core_example_read_issuer.sv
// Splits a transfer (start address, length in beats) into fixed-size AXI4 read
// bursts on AR, limits how many bursts are in flight, and pulses done once all return.
module pc_core_example_read_issuer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_xfer_size_in_beats,
  output logic                      ctrl_busy,
  output logic                      ctrl_done,
  output logic                      ctrl_err,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  input  logic                      r_last_accepted
);

  localparam int BURST_SHIFT = $clog2(C_BURST_LEN);
  localparam int OUT_W       = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_ADDR_WIDTH-1:0]   BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * (C_DATA_WIDTH / 8));
  localparam logic [C_LENGTH_WIDTH-1:0] LEN_MASK    = C_LENGTH_WIDTH'(C_BURST_LEN - 1);
  localparam logic [C_LENGTH_WIDTH-1:0] LEN_ONE     = C_LENGTH_WIDTH'(1);
  localparam logic [C_LENGTH_WIDTH-1:0] LEN_TWO     = C_LENGTH_WIDTH'(2);
  localparam logic [7:0]                FULL_ARLEN  = 8'(C_BURST_LEN - 1);
  localparam logic [OUT_W-1:0]          MAX_OUT     = OUT_W'(C_MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]          OUT_ONE     = OUT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                    state, state_d;
  logic                      busy_d, done_d, err_d, arvalid_d;
  logic [C_ADDR_WIDTH-1:0]   araddr_d;
  logic [7:0]                arlen_d;
  logic [C_LENGTH_WIDTH-1:0] bursts_remaining, bursts_d;
  logic [7:0]                last_arlen, last_arlen_d;
  logic [OUT_W-1:0]          outstanding, outstanding_d;
  logic                      ar_hs, r_last_err, start_accept;
  logic [C_LENGTH_WIDTH-1:0] size_rem, start_bursts;
  logic [7:0]                start_last_arlen;

  assign ar_hs        = m_axi_arvalid & m_axi_arready;
  assign start_accept = ctrl_start & (state == IDLE) & ~ctrl_busy;

  // Burst count is a ceiling divide; the final burst carries whatever is left over.
  assign size_rem         = ctrl_xfer_size_in_beats & LEN_MASK;
  assign start_bursts     = (ctrl_xfer_size_in_beats >> BURST_SHIFT)
                            + ((size_rem != '0) ? LEN_ONE : '0);
  assign start_last_arlen = (size_rem == '0) ? FULL_ARLEN : 8'(size_rem - LEN_ONE);

  // A simultaneous issue and return cancel; a return with nothing in flight is an error.
  always_comb begin
    outstanding_d = outstanding;
    r_last_err    = 1'b0;
    unique case ({ar_hs, r_last_accepted})
      2'b10: outstanding_d = outstanding + OUT_ONE;
      2'b01: begin
        if (outstanding == '0) r_last_err = 1'b1;
        else                   outstanding_d = outstanding - OUT_ONE;
      end
      2'b11: r_last_err = (outstanding == '0);
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state;
    busy_d       = ctrl_busy;
    done_d       = 1'b0;
    err_d        = ctrl_err;
    araddr_d     = m_axi_araddr;
    arlen_d      = m_axi_arlen;
    bursts_d     = bursts_remaining;
    last_arlen_d = last_arlen;
    unique case (state)
      IDLE: begin
        if (start_accept) begin
          araddr_d     = ctrl_addr_offset;
          bursts_d     = start_bursts;
          last_arlen_d = start_last_arlen;
          arlen_d      = (start_bursts == LEN_ONE) ? start_last_arlen : FULL_ARLEN;
          busy_d       = 1'b1;
          state_d      = (ctrl_xfer_size_in_beats == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          araddr_d = m_axi_araddr + BURST_BYTES;
          bursts_d = bursts_remaining - LEN_ONE;
          arlen_d  = (bursts_remaining == LEN_TWO) ? last_arlen : FULL_ARLEN;
          if (bursts_remaining == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (ctrl_done)    busy_d = 1'b0;
    if (start_accept) err_d  = 1'b0;
    if (r_last_err)   err_d  = 1'b1;
    // Looks at the post-update count so a freed slot is reused on the very next cycle.
    arvalid_d = (state_d == ISSUE) && (bursts_d != '0) && (outstanding_d < MAX_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ctrl_busy        <= 1'b0;
      ctrl_done        <= 1'b0;
      ctrl_err         <= 1'b0;
      m_axi_arvalid    <= 1'b0;
      m_axi_araddr     <= '0;
      m_axi_arlen      <= '0;
      bursts_remaining <= '0;
      last_arlen       <= '0;
      outstanding      <= '0;
    end else begin
      state            <= state_d;
      ctrl_busy        <= busy_d;
      ctrl_done        <= done_d;
      ctrl_err         <= err_d;
      m_axi_arvalid    <= arvalid_d;
      m_axi_araddr     <= araddr_d;
      m_axi_arlen      <= arlen_d;
      bursts_remaining <= bursts_d;
      last_arlen       <= last_arlen_d;
      outstanding      <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_pc_core_example_read_issuer.sv
// Scoreboard bench for pc_core_example_read_issuer: expected AR bursts are queued at
// start and popped by a monitor on each handshake; scenario tasks check control timing.
module tb_pc_core_example_read_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_start = 1'b0;
  logic [63:0] ctrl_addr_offset = '0;
  logic [31:0] ctrl_xfer_size_in_beats = '0;
  logic        ctrl_busy, ctrl_done, ctrl_err;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        r_last_accepted = 1'b0;

  pc_core_example_read_issuer #(
    .C_ADDR_WIDTH(64), .C_DATA_WIDTH(512), .C_LENGTH_WIDTH(32),
    .C_BURST_LEN(64), .C_MAX_OUTSTANDING(16)
  ) dut (
    .clk(clk), .rst(rst),
    .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_beats(ctrl_xfer_size_in_beats),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .r_last_accepted(r_last_accepted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ar_count = 0;
  logic        prev_pend = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;
  ar_t         mon_e;

  // AR monitor: stability under backpressure and scoreboard compare on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        n_checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== prev_addr || m_axi_arlen !== prev_len) begin
          n_fail++;
          $display("FAIL ar_stable: got valid=%0b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                   m_axi_arvalid, m_axi_araddr, m_axi_arlen, prev_addr, prev_len);
        end
      end
      if (m_axi_arvalid === 1'b1 && m_axi_arready === 1'b1) begin
        ar_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ar_unexpected: got addr=%h len=%0d, required no AR", m_axi_araddr, m_axi_arlen);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_axi_araddr !== mon_e.addr || m_axi_arlen !== mon_e.len) begin
            n_fail++;
            $display("FAIL ar_burst: got addr=%h len=%0d, required addr=%h len=%0d",
                     m_axi_araddr, m_axi_arlen, mon_e.addr, mon_e.len);
          end
        end
      end
      prev_pend = (m_axi_arvalid === 1'b1) && (m_axi_arready !== 1'b1);
      prev_addr = m_axi_araddr;
      prev_len  = m_axi_arlen;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bursts(input logic [63:0] addr, input int unsigned size);
    logic [63:0] a;
    int unsigned rem, n;
    ar_t e;
    a = addr;
    rem = size;
    while (rem > 0) begin
      n = (rem > 64) ? 64 : rem;
      e.addr = a;
      e.len = 8'(n - 1);
      exp_q.push_back(e);
      a = a + 64'h1000;
      rem = rem - n;
    end
  endtask

  task automatic do_start(input logic [63:0] addr, input logic [31:0] size);
    ctrl_addr_offset = addr;
    ctrl_xfer_size_in_beats = size;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen, ctrl_busy, ctrl_done, ctrl_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%0b addr=%h len=%0d busy=%0b done=%0b err=%0b, required all 0",
               m_axi_arvalid, m_axi_araddr, m_axi_arlen, ctrl_busy, ctrl_done, ctrl_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_len();
    do_start(64'h5000, 32'd0);
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ctrl_busy !== 1'b1 || ctrl_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_n1: got valid=%0b busy=%0b done=%0b, required 0 1 0", m_axi_arvalid, ctrl_busy, ctrl_done);
    end
    tick();
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ctrl_busy !== 1'b1 || ctrl_done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_len_n2: got valid=%0b busy=%0b done=%0b, required 0 1 1", m_axi_arvalid, ctrl_busy, ctrl_done);
    end
    tick();
    n_checks++;
    if (ctrl_busy !== 1'b0 || ctrl_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_n3: got busy=%0b done=%0b, required 0 0", ctrl_busy, ctrl_done);
    end
  endtask

  task automatic test_single_burst(input logic [63:0] addr);
    int c0;
    c0 = ar_count;
    m_axi_arready = 1'b1;
    push_bursts(addr, 64);
    do_start(addr, 32'd64);
    n_checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== addr || m_axi_arlen !== 8'd63 || ctrl_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ar: got valid=%0b addr=%h len=%0d err=%0b, required 1 %h 63 0",
               m_axi_arvalid, m_axi_araddr, m_axi_arlen, ctrl_err, addr);
    end
    tick();
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ctrl_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after_ar: got valid=%0b busy=%0b, required 0 1", m_axi_arvalid, ctrl_busy);
    end
    // start while busy must be dropped
    do_start(64'h9000, 32'd64);
    repeat (8) tick();
    r_last_accepted = 1'b1;
    tick();
    r_last_accepted = 1'b0;
    n_checks++;
    if (ctrl_done !== 1'b0 || ctrl_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_m1: got done=%0b busy=%0b, required 0 1", ctrl_done, ctrl_busy);
    end
    tick();
    n_checks++;
    if (ctrl_done !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: got done=%0b, required 1", ctrl_done);
    end
    tick();
    n_checks++;
    if (ctrl_done !== 1'b0 || ctrl_busy !== 1'b0 || ctrl_err !== 1'b0 || ar_count - c0 !== 1) begin
      n_fail++;
      $display("FAIL single_end: got done=%0b busy=%0b err=%0b ars=%0d, required 0 0 0 1",
               ctrl_done, ctrl_busy, ctrl_err, ar_count - c0);
    end
    m_axi_arready = 1'b0;
  endtask

  task automatic test_partial();
    int c0;
    c0 = ar_count;
    m_axi_arready = 1'b1;
    push_bursts(64'h20000, 130);
    do_start(64'h20000, 32'd130);
    repeat (3) tick();
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ar_count - c0 !== 3) begin
      n_fail++;
      $display("FAIL partial_ars: got valid=%0b ars=%0d, required 0 3", m_axi_arvalid, ar_count - c0);
    end
    for (int i = 0; i < 2; i++) begin
      r_last_accepted = 1'b1;
      tick();
      r_last_accepted = 1'b0;
      tick();
    end
    repeat (3) begin
      n_checks++;
      if (ctrl_done !== 1'b0 || ctrl_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL partial_early_done: got done=%0b busy=%0b, required 0 1", ctrl_done, ctrl_busy);
      end
      tick();
    end
    r_last_accepted = 1'b1;
    tick();
    r_last_accepted = 1'b0;
    tick();
    n_checks++;
    if (ctrl_done !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_done: got done=%0b, required 1", ctrl_done);
    end
    tick();
    m_axi_arready = 1'b0;
  endtask

  task automatic test_outstanding_limit();
    int c0;
    logic seen;
    c0 = ar_count;
    seen = 1'b0;
    m_axi_arready = 1'b1;
    push_bursts(64'h100000, 64 * 20);
    do_start(64'h100000, 32'd1280);
    repeat (20) tick();
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ar_count - c0 !== 16) begin
      n_fail++;
      $display("FAIL limit_fill: got valid=%0b ars=%0d, required 0 16", m_axi_arvalid, ar_count - c0);
    end
    r_last_accepted = 1'b1;
    tick();
    r_last_accepted = 1'b0;
    n_checks++;
    if (m_axi_arvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_refill: got valid=%0b, required 1", m_axi_arvalid);
    end
    tick();
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ar_count - c0 !== 17) begin
      n_fail++;
      $display("FAIL limit_one_more: got valid=%0b ars=%0d, required 0 17", m_axi_arvalid, ar_count - c0);
    end
    for (int i = 0; i < 19; i++) begin
      r_last_accepted = 1'b1;
      tick();
      r_last_accepted = 1'b0;
      if (i != 18) tick();
    end
    for (int k = 0; k < 40; k++) begin
      if (ctrl_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (seen !== 1'b1 || ar_count - c0 !== 20 || ctrl_err !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_done: got done_seen=%0b ars=%0d err=%0b, required 1 20 0", seen, ar_count - c0, ctrl_err);
    end
    tick();
    m_axi_arready = 1'b0;
  endtask

  task automatic test_overlap();
    int c0;
    logic seen;
    c0 = ar_count;
    seen = 1'b0;
    m_axi_arready = 1'b0;
    push_bursts(64'h300000, 64 * 18);
    do_start(64'h300000, 32'd1152);
    m_axi_arready = 1'b1;
    repeat (15) tick();
    n_checks++;
    if (m_axi_arvalid !== 1'b1 || ar_count - c0 !== 15) begin
      n_fail++;
      $display("FAIL overlap_pre: got valid=%0b ars=%0d, required 1 15", m_axi_arvalid, ar_count - c0);
    end
    r_last_accepted = 1'b1;
    tick();
    r_last_accepted = 1'b0;
    m_axi_arready = 1'b0;
    n_checks++;
    if (m_axi_arvalid !== 1'b1 || ar_count - c0 !== 16) begin
      n_fail++;
      $display("FAIL overlap_same_cycle: got valid=%0b ars=%0d, required 1 16", m_axi_arvalid, ar_count - c0);
    end
    tick();
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ar_count - c0 !== 17) begin
      n_fail++;
      $display("FAIL overlap_at_limit: got valid=%0b ars=%0d, required 0 17", m_axi_arvalid, ar_count - c0);
    end
    m_axi_arready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      r_last_accepted = 1'b1;
      tick();
      r_last_accepted = 1'b0;
      if (i != 16) tick();
    end
    for (int k = 0; k < 40; k++) begin
      if (ctrl_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (seen !== 1'b1 || ar_count - c0 !== 18 || ctrl_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_done: got done_seen=%0b ars=%0d err=%0b, required 1 18 0", seen, ar_count - c0, ctrl_err);
    end
    tick();
    m_axi_arready = 1'b0;
  endtask

  task automatic test_backpressure();
    int c0, returned;
    logic seen;
    c0 = ar_count;
    returned = 0;
    seen = 1'b0;
    push_bursts(64'hFFFF_FFFF_FFFF_E000, 64 * 6);
    do_start(64'hFFFF_FFFF_FFFF_E000, 32'd384);
    for (int k = 0; k < 400; k++) begin
      m_axi_arready = 1'($urandom_range(0, 1));
      r_last_accepted = ((ar_count - c0) > returned) && ($urandom_range(0, 2) == 0);
      if (r_last_accepted) returned++;
      tick();
      if (ctrl_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    r_last_accepted = 1'b0;
    m_axi_arready = 1'b0;
    n_checks++;
    if (seen !== 1'b1 || returned !== 6 || ar_count - c0 !== 6 || exp_q.size() !== 0 || ctrl_err !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_done: got done_seen=%0b returned=%0d ars=%0d left=%0d err=%0b, required 1 6 6 0 0",
               seen, returned, ar_count - c0, exp_q.size(), ctrl_err);
    end
    tick();
  endtask

  task automatic test_err_and_reset();
    r_last_accepted = 1'b1;
    tick();
    r_last_accepted = 1'b0;
    n_checks++;
    if (ctrl_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_idle_set: got err=%0b, required 1", ctrl_err);
    end
    repeat (3) tick();
    n_checks++;
    if (ctrl_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%0b, required 1", ctrl_err);
    end
    m_axi_arready = 1'b0;
    push_bursts(64'h40000, 256);
    do_start(64'h40000, 32'd256);
    n_checks++;
    if (ctrl_err !== 1'b0 || m_axi_arvalid !== 1'b1 || ctrl_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cleared_on_start: got err=%0b valid=%0b busy=%0b, required 0 1 1",
               ctrl_err, m_axi_arvalid, ctrl_busy);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ctrl_busy !== 1'b0 || m_axi_araddr !== 64'h0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%0b busy=%0b addr=%h, required 0 0 0",
               m_axi_arvalid, ctrl_busy, m_axi_araddr);
    end
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    r_last_accepted = 1'b1;
    tick();
    r_last_accepted = 1'b0;
    n_checks++;
    if (ctrl_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_after_reset: got err=%0b, required 1", ctrl_err);
    end
    tick();
    test_single_burst(64'h1000);
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_single_burst(64'h1000);
    test_partial();
    test_outstanding_limit();
    test_overlap();
    test_backpressure();
    test_err_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
